// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings,
// FSM state type, default latencies and a small magnitude helper.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 16;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_calc.sv
// Combinational datapath for mult/multu/div/divu. Signed division is
// done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
module md_calc
  import md_defs::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] divisor_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Select and compute the 64-bit {HI,LO} result for the decoded operation.
  always_comb begin
    prod_s      = 64'd0;
    mag_a_s     = 32'd0;
    mag_b_s     = 32'd0;
    divisor_s   = 32'd1;
    quot_s      = 32'd0;
    rem_s       = 32'd0;
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (md_op_e'(md_op))
      MD_MULT: begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        prod_s = {32'd0, A} * {32'd0, B};
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_DIV: begin
        mag_a_s     = abs32(A);
        mag_b_s     = abs32(B);
        divisor_s   = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
        quot_s      = mag_a_s / divisor_s;
        rem_s       = mag_a_s % divisor_s;
        res_lo      = (A[31] ^ B[31]) ? (32'd0 - quot_s) : quot_s;
        res_hi      = A[31] ? (32'd0 - rem_s) : rem_s;
        div_by_zero = (B == 32'd0);
      end
      MD_DIVU: begin
        divisor_s   = (B == 32'd0) ? 32'd1 : B;
        res_lo      = A / divisor_s;
        res_hi      = A % divisor_s;
        div_by_zero = (B == 32'd0);
      end
      default: begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result
// is computed at the start edge, held, and committed after N busy cycles.
module mult_div
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] md_out
);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      res_hi_r;
  logic [31:0]      res_lo_r;
  logic             dbz_r;
  logic             busy_r;

  logic [31:0]      calc_hi_s;
  logic [31:0]      calc_lo_s;
  logic             calc_dbz_s;

  md_calc u_calc (
    .A           (A),
    .B           (B),
    .md_op       (md_op),
    .res_hi      (calc_hi_s),
    .res_lo      (calc_lo_s),
    .div_by_zero (calc_dbz_s)
  );

  // FSM: accept ops in IDLE, count down in BUSY, commit HI/LO at cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      dbz_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU: begin
                res_hi_r <= calc_hi_s;
                res_lo_r <= calc_lo_s;
                dbz_r    <= 1'b0;
                cnt_r    <= CNT_W'(MULT_CYCLES - 1);
                state_r  <= ST_BUSY;
                busy_r   <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                res_hi_r <= calc_hi_s;
                res_lo_r <= calc_lo_s;
                dbz_r    <= calc_dbz_s;
                cnt_r    <= CNT_W'(DIV_CYCLES - 1);
                state_r  <= ST_BUSY;
                busy_r   <= 1'b1;
              end
              MD_MTHI: hi_r <= A;
              MD_MTLO: lo_r <= A;
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            if (!dbz_r) begin
              hi_r <= res_hi_r;
              lo_r <= res_lo_r;
            end
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign md_out = rd_hi ? hi_r : lo_r;

endmodule
